// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then clocks a command
// byte out on device-generated falling edges and collects the device ACK. Lines are open-drain.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES     = 6000,
  parameter int unsigned FIRST_EDGE_TIMEOUT = 750000,
  parameter int unsigned BIT_TIMEOUT        = 100000,
  parameter int unsigned FILTER_LEN         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned WdMax = (FIRST_EDGE_TIMEOUT > BIT_TIMEOUT) ? FIRST_EDGE_TIMEOUT
                                                                     : BIT_TIMEOUT;
  localparam int unsigned WdW   = $clog2(WdMax + 1);
  localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned FltW  = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRequest,
    StData,
    StAck,
    StWaitIdle,
    StDone
  } state_e;

  // Index 0 is the PS/2 clock, index 1 the PS/2 data line.
  logic [1:0]      sync1_q, sync2_q, filt_q;
  logic [FltW-1:0] flt_cnt_q [2];
  logic [1:0]      flip;
  logic            fe;

  always_comb begin
    flip = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (sync2_q[i] != filt_q[i]) && (flt_cnt_q[i] == FltW'(FILTER_LEN - 1));
    end
  end

  // Falling edge is flagged in the cycle the filtered clock is about to drop.
  assign fe = flip[0] && filt_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 2'b11;
      sync2_q      <= 2'b11;
      filt_q       <= 2'b11;
      flt_cnt_q[0] <= '0;
      flt_cnt_q[1] <= '0;
    end else begin
      sync1_q <= {ps2_dat_in, ps2_clk_in};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flip[i]) begin
          filt_q[i]    <= sync2_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + FltW'(1);
        end
      end
    end
  end

  state_e          state_q;
  logic [7:0]      data_q;
  logic            par_q;
  logic [3:0]      n_q;
  logic            err_q;
  logic [InhW-1:0] inh_q;
  logic [WdW-1:0]  wd_q;
  logic [9:0]      frame;
  logic            watched;
  logic            progress;

  // Bits presented after falling edges 1..10: data LSB first, parity, stop.
  assign frame = {1'b1, par_q, data_q};

  always_comb begin
    watched  = 1'b0;
    progress = 1'b0;
    case (state_q)
      StRequest, StData, StAck: begin
        watched  = 1'b1;
        progress = fe;
      end
      StWaitIdle: begin
        watched  = 1'b1;
        progress = &filt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      busy       <= 1'b0;
      tx_ready   <= 1'b1;
      data_q     <= '0;
      par_q      <= 1'b0;
      n_q        <= '0;
      err_q      <= 1'b0;
      inh_q      <= '0;
      wd_q       <= '0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (wd_q != '0) wd_q <= wd_q - WdW'(1);

      if (watched && (wd_q == '0) && !progress) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_done    <= 1'b1;
        tx_error   <= 1'b1;
        state_q    <= StDone;
      end else begin
        case (state_q)
          StIdle: begin
            if (tx_valid) begin
              data_q     <= tx_data;
              par_q      <= ~^tx_data;
              n_q        <= '0;
              err_q      <= 1'b0;
              inh_q      <= InhW'(INHIBIT_CYCLES - 1);
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state_q    <= StInhibit;
            end
          end
          StInhibit: begin
            inh_q <= inh_q - InhW'(1);
            if (inh_q == InhW'(1)) ps2_dat_oe <= 1'b1;
            if (inh_q == '0) begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              wd_q       <= WdW'(FIRST_EDGE_TIMEOUT - 1);
              state_q    <= StRequest;
            end
          end
          StRequest, StData: begin
            if (fe) begin
              ps2_dat_oe <= ~frame[n_q];
              n_q        <= n_q + 4'd1;
              wd_q       <= WdW'(BIT_TIMEOUT - 1);
              state_q    <= (n_q == 4'd9) ? StAck : StData;
            end
          end
          StAck: begin
            if (fe) begin
              err_q   <= filt_q[1];
              wd_q    <= WdW'(BIT_TIMEOUT - 1);
              state_q <= StWaitIdle;
            end
          end
          StWaitIdle: begin
            if (&filt_q) begin
              tx_done  <= 1'b1;
              tx_error <= err_q;
              state_q  <= StDone;
            end
          end
          StDone: begin
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT over wired-AND lines
// and each frame is compared against the byte, odd parity and ACK the bench chose.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int InhCyc  = 50;
  localparam int FirstTo = 1000;
  localparam int BitTo   = 500;
  localparam int FiltLen = 8;
  localparam int Half    = 150;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk, dev_dat;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int          err_alone = 0;
  logic        last_done_err;
  int unsigned last_done_cyc;
  logic [1:0]  last_done_oe;
  int unsigned fall_cyc;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES    (InhCyc),
    .FIRST_EDGE_TIMEOUT(FirstTo),
    .BIT_TIMEOUT       (BitTo),
    .FILTER_LEN        (FiltLen)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .busy      (busy),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done === 1'b1) begin
      done_cnt      <= done_cnt + 1;
      last_done_err <= tx_error;
      last_done_cyc <= cyc;
      last_done_oe  <= {ps2_clk_oe, ps2_dat_oe};
    end
    if (tx_error === 1'b1 && tx_done !== 1'b1) err_alone <= err_alone + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    check("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  task automatic measure_inhibit(output int len, output logic dat_rel, output int unsigned rel);
    len = 0;
    while (ps2_clk_oe === 1'b1 && len < 20000) begin
      len++;
      @(negedge clk);
    end
    dat_rel = ps2_dat_oe;
    rel     = cyc;
  endtask

  // Device clocks nfe falling edges; smp[0] is the line before the first edge,
  // smp[k] is the line at the rising edge following falling edge k.
  task automatic device_run(input int nfe, input bit ack, output logic [11:0] smp);
    smp    = '0;
    smp[0] = ps2_dat_in;
    for (int k = 1; k <= nfe; k++) begin
      if (k == 11) begin
        dev_dat = ~ack;
        wait_cyc(Half / 2);
      end
      dev_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cyc(Half);
      dev_clk = 1'b1;
      smp[k]  = ps2_dat_in;
      wait_cyc(Half);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_done(input int prev, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_cnt != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_window(input int n, output int active);
    active = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ps2_clk_oe !== 1'b0 || busy !== 1'b0) active++;
    end
  endtask

  task automatic do_xfer(input logic [7:0] d, input bit ack);
    int          prev;
    int          len;
    int          act;
    logic        dat_rel;
    int unsigned rel;
    logic [11:0] smp;
    bit          ok;
    logic        exp_par;
    prev    = done_cnt;
    exp_par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    start_tx(d);
    measure_inhibit(len, dat_rel, rel);
    check("inhibit_len", 32'(len), 32'(InhCyc));
    check("start_low_at_release", {31'd0, dat_rel}, 32'd1);
    check("busy_in_request", {31'd0, busy}, 32'd1);
    tx_valid = 1'b1;
    tx_data  = ~d;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_cyc($urandom_range(50, 400));
    device_run(11, ack, smp);
    check("start_bit", {31'd0, smp[0]}, 32'd0);
    check("data_bits", {24'd0, smp[8:1]}, {24'd0, d});
    check("parity_bit", {31'd0, smp[9]}, {31'd0, exp_par});
    check("stop_bit", {31'd0, smp[10]}, 32'd1);
    wait_done(prev, 3000, ok);
    check("done_seen", {31'd0, ok}, 32'd1);
    check("done_count", 32'(done_cnt), 32'(prev + 1));
    check("tx_error", {31'd0, last_done_err}, {31'd0, ~ack});
    check("oe_at_done", {30'd0, last_done_oe}, 32'd0);
    check("ready_after_done", {31'd0, tx_ready}, 32'd1);
    idle_window(300, act);
    check("busy_request_not_queued", 32'(act), 32'd0);
  endtask

  initial begin
    int          prev;
    int          len;
    int          act;
    logic        dat_rel;
    int unsigned rel;
    logic [11:0] smp;
    bit          ok;
    logic [7:0]  d;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    wait_cyc(4);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("rst_done", {30'd0, tx_done, tx_error}, 32'd0);
    reset = 1'b0;
    wait_cyc(20);

    do_xfer(8'hED, 1'b1);
    do_xfer(8'hF4, 1'b1);
    do_xfer(8'h00, 1'b0);

    // Device never clocks: watchdog counts from the clock release.
    prev = done_cnt;
    start_tx(8'h55);
    measure_inhibit(len, dat_rel, rel);
    check("noclk_inhibit_len", 32'(len), 32'(InhCyc));
    wait_done(prev, 3000, ok);
    check("noclk_done_seen", {31'd0, ok}, 32'd1);
    check("noclk_timeout_cycles", last_done_cyc - rel, 32'(FirstTo));
    check("noclk_error", {31'd0, last_done_err}, 32'd1);
    check("noclk_oe", {30'd0, last_done_oe}, 32'd0);
    check("noclk_ready", {31'd0, tx_ready}, 32'd1);

    // Device stops after its fourth falling edge.
    prev = done_cnt;
    start_tx(8'hA5);
    measure_inhibit(len, dat_rel, rel);
    wait_cyc(100);
    device_run(4, 1'b1, smp);
    wait_done(prev, 3000, ok);
    check("stall_done_seen", {31'd0, ok}, 32'd1);
    check("stall_timeout_cycles", last_done_cyc - fall_cyc, 32'(BitTo + 2 + FiltLen));
    check("stall_error", {31'd0, last_done_err}, 32'd1);
    check("stall_oe", {30'd0, last_done_oe}, 32'd0);
    wait_cyc(50);
    do_xfer(8'hFF, 1'b1);

    for (int i = 0; i < 3; i++) begin
      do_xfer(8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of DATA with the data line pulled low.
    prev = done_cnt;
    d    = 8'($urandom) & 8'hFB;
    start_tx(d);
    measure_inhibit(len, dat_rel, rel);
    wait_cyc(100);
    device_run(3, 1'b1, smp);
    check("mid_data_dat_driven", {31'd0, ps2_dat_oe}, 32'd1);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle_window(500, act);
    check("midrst_no_transfer", 32'(act), 32'd0);
    check("midrst_no_done", 32'(done_cnt), 32'(prev));
    check("error_without_done", 32'(err_alone), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
